// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin share of one data-memory port between core (re/we/addr/wdata, stall) and DMA (req/gnt/done), fixed MEM_LAT access, registered mem_* and rdata
module dmem_arbiter #(
  parameter int DW = 32,
  parameter int AW = 32,
  parameter int MEM_LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          core_re,
  input  logic          core_we,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  output logic [DW-1:0] core_rdata,
  output logic          core_stall,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_gnt,
  output logic          dma_done,
  output logic [DW-1:0] dma_rdata,
  output logic          mem_re,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);
  localparam int CW = MEM_LAT > 1 ? $clog2(MEM_LAT) : 1;
  typedef enum logic {IDLE, ACCESS} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic last_dma, own_dma, core_done;
  logic core_req, cr, dr, gnt, gnt_dma, fin, we_n;
  assign core_req = core_re | core_we;
  assign cr = core_req & ~core_done;
  assign dr = dma_req & ~dma_done;
  assign gnt = state == IDLE && (cr | dr);
  assign gnt_dma = dr & (~cr | ~last_dma);
  assign fin = state == ACCESS && cnt == '0;
  assign we_n = gnt_dma ? dma_we : core_we;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb state_n = gnt ? ACCESS : fin ? IDLE : state;
  always_comb core_stall = ~rst & core_req & ~core_done;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      last_dma <= 1'b1;
      own_dma <= 1'b0;
      core_done <= 1'b0;
      dma_done <= 1'b0;
      dma_gnt <= 1'b0;
      mem_re <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      core_rdata <= '0;
      dma_rdata <= '0;
    end else begin
      dma_gnt <= gnt & gnt_dma;
      core_done <= fin & ~own_dma;
      dma_done <= fin & own_dma;
      if (gnt) begin
        own_dma <= gnt_dma;
        last_dma <= gnt_dma;
        cnt <= CW'(MEM_LAT - 1);
        mem_re <= ~we_n;
        mem_we <= we_n;
        mem_addr <= gnt_dma ? dma_addr : core_addr;
        mem_wdata <= gnt_dma ? dma_wdata : core_wdata;
      end else if (state == ACCESS) cnt <= cnt - 1'b1;
      if (fin) begin
        mem_re <= 1'b0;
        mem_we <= 1'b0;
        if (~mem_we & ~own_dma) core_rdata <= mem_rdata;
        if (~mem_we & own_dma) dma_rdata <= mem_rdata;
      end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed vector table, reset/cancel sequences and randomized run against a transaction-timing model
module tb_dmem_arbiter;
  localparam int DW = 32, AW = 32, LAT = 2;
  logic clk = 0, rst, init;
  logic core_re, core_we, core_stall, dma_req, dma_we, dma_gnt, dma_done, mem_re, mem_we;
  logic [AW-1:0] core_addr, dma_addr, mem_addr;
  logic [DW-1:0] core_wdata, core_rdata, dma_wdata, dma_rdata, mem_wdata, mem_rdata;
  logic [DW-1:0] mem [256];
  logic [DW-1:0] ref_mem [256];
  int checks = 0, failures = 0;
  dmem_arbiter #(.DW(DW), .AW(AW), .MEM_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .core_re(core_re), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_rdata(core_rdata), .core_stall(core_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_done(dma_done), .dma_rdata(dma_rdata),
    .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata));
  always #5 clk = ~clk;
  always @(posedge clk)
    if (init) for (int i = 0; i < 256; i++) mem[i] <= (i == 16) ? 32'hDEADBEEF : 32'(i);
    else if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
  assign mem_rdata = mem[mem_addr[7:0]];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  typedef struct {
    logic c_re, c_we; logic [7:0] c_a; logic [31:0] c_wd;
    logic d_req, d_we; logic [7:0] d_a; logic [31:0] d_wd;
    logic [31:0] e_crd, e_drd; int e_re, e_we, e_stall; logic e_cfirst;
  } vec_t;
  vec_t tv[9];
  task automatic run_vec(input vec_t v, input string nm);
    int nre = 0, nwe = 0, nst = 0, ngnt = 0, t = 0;
    bit cp, dp, c_rel = 0, d_rel = 0, cfirst = 0;
    core_re = v.c_re; core_we = v.c_we; core_addr = AW'(v.c_a); core_wdata = v.c_wd;
    dma_req = v.d_req; dma_we = v.d_we; dma_addr = AW'(v.d_a); dma_wdata = v.d_wd;
    cp = v.c_re | v.c_we; dp = v.d_req;
    #1 if (core_stall) nst++;
    while ((cp || dp) && t < 40) begin
      @(posedge clk); #1; t++;
      if (c_rel) begin core_re = 0; core_we = 0; c_rel = 0; end
      if (d_rel) begin dma_req = 0; d_rel = 0; end
      nre += int'(mem_re); nwe += int'(mem_we); ngnt += int'(dma_gnt);
      if (cp) begin
        if (core_stall) nst++;
        else begin cp = 0; c_rel = 1; if (dp) cfirst = 1; end
      end
      if (dp && dma_done) begin dp = 0; d_rel = 1; end
    end
    chk({nm, " timeout"}, 64'(cp | dp), 0);
    @(posedge clk); #1;
    nre += int'(mem_re); nwe += int'(mem_we); ngnt += int'(dma_gnt);
    core_re = 0; core_we = 0; dma_req = 0;
    @(posedge clk); #1;
    nre += int'(mem_re); nwe += int'(mem_we); ngnt += int'(dma_gnt);
    chk({nm, " core_rdata"}, 64'(core_rdata), 64'(v.e_crd));
    chk({nm, " dma_rdata"}, 64'(dma_rdata), 64'(v.e_drd));
    chk({nm, " re_cycles"}, 64'(nre), 64'(v.e_re));
    chk({nm, " we_cycles"}, 64'(nwe), 64'(v.e_we));
    chk({nm, " stall_cycles"}, 64'(nst), 64'(v.e_stall));
    chk({nm, " gnt_pulses"}, 64'(ngnt), 64'(v.d_req));
    if ((v.c_re | v.c_we) && v.d_req) chk({nm, " core_first"}, 64'(cfirst), 64'(v.e_cfirst));
  endtask
  bit busy, o_dma, o_we, last_dma, e_cd, e_dd, e_g, e_r, e_w, cr, dr;
  int st, cyc, r, nst, ng, nd, nw;
  logic [7:0] o_a;
  logic [31:0] o_wd, e_crd, e_drd;
  initial begin
    tv[0] = '{1, 0, 8'h10, 0, 0, 0, 0, 0, 32'hDEADBEEF, 0, 2, 0, 3, 1};
    tv[1] = '{0, 0, 0, 0, 1, 1, 8'h20, 32'h1234, 32'hDEADBEEF, 0, 0, 2, 0, 0};
    tv[2] = '{1, 0, 8'h20, 0, 0, 0, 0, 0, 32'h1234, 0, 2, 0, 3, 1};
    tv[3] = '{1, 1, 8'h30, 32'h55, 0, 0, 0, 0, 32'h1234, 0, 0, 2, 3, 1};
    tv[4] = '{0, 0, 0, 0, 1, 0, 8'h30, 0, 32'h1234, 32'h55, 2, 0, 0, 0};
    tv[5] = '{1, 0, 8'h10, 0, 1, 0, 8'h20, 0, 32'hDEADBEEF, 32'h1234, 4, 0, 3, 1};
    tv[6] = '{1, 0, 8'h30, 0, 0, 0, 0, 0, 32'h55, 32'h1234, 2, 0, 3, 1};
    tv[7] = '{1, 0, 8'h20, 0, 1, 1, 8'h10, 32'hABCD, 32'h1234, 32'h1234, 2, 2, 6, 0};
    tv[8] = '{1, 0, 8'h10, 0, 0, 0, 0, 0, 32'hABCD, 32'h1234, 2, 0, 3, 1};
    init = 1; rst = 1; core_re = 1; core_we = 0; core_addr = 0; core_wdata = 0;
    dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst core_stall", 64'(core_stall), 0);
    chk("rst mem_en", {mem_re, mem_we}, 0);
    chk("rst pulses", {dma_gnt, dma_done}, 0);
    chk("rst rdata", {core_rdata, dma_rdata}, 0);
    chk("rst mem_addr", 64'(mem_addr), 0);
    core_re = 0; init = 0; rst = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 9; i++) run_vec(tv[i], $sformatf("vec%0d", i));
    core_we = 1; core_addr = 32'h50; core_wdata = 32'h99;
    @(posedge clk); #1;
    chk("midrst we_before", 64'(mem_we), 1);
    rst = 1; #1;
    chk("midrst en_drop", {mem_re, mem_we}, 0);
    chk("midrst stall", 64'(core_stall), 0);
    @(posedge clk); #1;
    chk("midrst done", {dma_done, dma_gnt}, 0);
    chk("midrst rdata", {core_rdata, dma_rdata}, 0);
    chk("midrst nowrite", 64'(mem[8'h50]), 64'h50);
    rst = 0; nst = 0; #1;
    for (int t = 0; t < 20 && core_stall; t++) begin nst++; @(posedge clk); #1; end
    core_we = 0;
    chk("midrst rearb_stall", 64'(nst), 3);
    @(posedge clk); #1;
    chk("midrst write", 64'(mem[8'h50]), 64'h99);
    chk("midrst core_rdata", 64'(core_rdata), 0);
    core_re = 1; core_addr = 32'h10; ng = 0; nd = 0; nw = 0;
    for (int t = 0; t < 10; t++) begin
      @(posedge clk); #1;
      ng += int'(dma_gnt); nd += int'(dma_done); nw += int'(mem_we);
      if (core_re && !core_stall) core_re = 0;
      if (t == 0) begin dma_req = 1; dma_we = 1; dma_addr = 32'h60; dma_wdata = 32'hBAD; end
      if (t == 1) dma_req = 0;
    end
    chk("cancel gnt", 64'(ng), 0);
    chk("cancel done", 64'(nd), 0);
    chk("cancel we", 64'(nw), 0);
    chk("cancel mem", 64'(mem[8'h60]), 64'h60);
    chk("cancel core_rdata", 64'(core_rdata), 64'hABCD);
    rst = 1; core_re = 0; core_we = 0; dma_req = 0;
    @(posedge clk); #1;
    rst = 0;
    for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
    busy = 0; last_dma = 1; e_cd = 0; e_dd = 0; cyc = 0; e_crd = 0; e_drd = 0; st = 0;
    o_dma = 0; o_we = 0; o_a = 0; o_wd = 0;
    for (int k = 0; k < 3000; k++) begin
      cr = (core_re | core_we) && !e_cd;
      dr = dma_req && !e_dd;
      if (!busy && (cr || dr)) begin
        o_dma = (cr && dr) ? !last_dma : dr;
        last_dma = o_dma; busy = 1; st = cyc;
        o_we = o_dma ? dma_we : core_we;
        o_a = o_dma ? dma_addr[7:0] : core_addr[7:0];
        o_wd = o_dma ? dma_wdata : core_wdata;
      end
      @(posedge clk); #1; cyc++;
      e_g = busy && o_dma && cyc == st + 1;
      e_r = busy && cyc <= st + LAT && !o_we;
      e_w = busy && cyc <= st + LAT && o_we;
      e_cd = 0; e_dd = 0;
      if (busy && cyc == st + LAT + 1) begin
        busy = 0;
        if (o_dma) e_dd = 1; else e_cd = 1;
        if (o_we) ref_mem[o_a] = o_wd;
        else if (o_dma) e_drd = ref_mem[o_a];
        else e_crd = ref_mem[o_a];
      end
      chk("rnd mem_re", 64'(mem_re), 64'(e_r));
      chk("rnd mem_we", 64'(mem_we), 64'(e_w));
      chk("rnd dma_gnt", 64'(dma_gnt), 64'(e_g));
      chk("rnd dma_done", 64'(dma_done), 64'(e_dd));
      chk("rnd core_rdata", 64'(core_rdata), 64'(e_crd));
      chk("rnd dma_rdata", 64'(dma_rdata), 64'(e_drd));
      if (e_r || e_w) chk("rnd mem_addr", 64'(mem_addr), 64'(o_a));
      if (e_w) chk("rnd mem_wdata", 64'(mem_wdata), 64'(o_wd));
      if (e_cd) begin core_re = 0; core_we = 0; end
      if (!(core_re | core_we) && $urandom_range(0, 2) == 0) begin
        r = int'($urandom_range(1, 3));
        core_re = r[0]; core_we = r[1];
        core_addr = AW'($urandom_range(0, 15)); core_wdata = $urandom;
      end
      if (e_dd) dma_req = 0;
      else if (dma_req && !(busy && o_dma) && $urandom_range(0, 7) == 0) dma_req = 0;
      if (!dma_req && $urandom_range(0, 3) == 0) begin
        dma_req = 1; dma_we = 1'($urandom_range(0, 1));
        dma_addr = AW'($urandom_range(0, 15)); dma_wdata = $urandom;
      end
      #1 chk("rnd core_stall", 64'(core_stall), 64'((core_re | core_we) && !e_cd));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
